// File: rtl/beats_pkg.sv
// Shared helpers for beat-width converters: lane counter sizing and lane slicing.
package beats_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } upsizer_state_e;

    // A one-lane counter still needs one bit to exist.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Lane i occupies bits [i*data_wd +: data_wd] of the packed word.
    function automatic int lane_lo(input int lane, input int data_wd);
        return lane * data_wd;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word with a per-lane keep mask;
// last_in closes a word early.
module stream_upsizer
    import beats_pkg::*;
#(
    parameter int DATA_WD = 8,
    parameter int RATIO   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [DATA_WD-1:0]       data_in,
    input  logic                     last_in,
    output logic                     ready_in,
    output logic                     valid_out,
    output logic [DATA_WD*RATIO-1:0] data_out,
    output logic [RATIO-1:0]         keep_out,
    output logic                     last_out,
    input  logic                     ready_out
);

    localparam int CNT_WD = cnt_width(RATIO);

    upsizer_state_e           state_q, state_d;
    logic [CNT_WD-1:0]        cnt_q, cnt_d;
    logic                     last_q, last_d;
    logic [DATA_WD*RATIO-1:0] word_q, word_d;
    logic [RATIO-1:0]         keep_q, keep_d;
    logic [RATIO-1:0]         lane_we;
    logic                     fire_in, fire_out, word_start, close_word;

    // Handshake: a transfer happens only when valid and ready are both high on a
    // clock edge; the source holds valid and payload until then. ready_in is the
    // single combinational input-to-output path (!valid_out | ready_out).
    assign valid_out  = (state_q == ST_HOLD);
    assign ready_in   = !valid_out || ready_out;
    assign fire_in    = valid_in && ready_in;
    assign fire_out   = valid_out && ready_out;
    assign word_start = fire_out;
    assign close_word = last_in || (cnt_q == CNT_WD'(RATIO - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (fire_out) begin
            state_d = ST_FILL;
            last_d  = 1'b0;
        end
        // In HOLD cnt is 0, so a beat accepted during drain lands in lane 0.
        if (fire_in) begin
            if (close_word) begin
                state_d = ST_HOLD;
                last_d  = last_in;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_WD'(1);
            end
        end
    end

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign lane_we[i] = fire_in && (cnt_q == CNT_WD'(i));
        assign word_d[lane_lo(i, DATA_WD) +: DATA_WD] =
            lane_we[i]  ? data_in :
            word_start  ? '0      : word_q[lane_lo(i, DATA_WD) +: DATA_WD];
        assign keep_d[i] = lane_we[i] || (!word_start && keep_q[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            word_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
        end
    end

    assign data_out = word_q;
    assign keep_out = keep_q;
    assign last_out = last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: RATIO=4 main instance plus a RATIO=3 instance,
// each checked against a packing model through an expected-word queue.
module tb_stream_upsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RATIO=4 instance
    logic        valid_in = 1'b0, last_in = 1'b0, ready_out = 1'b0;
    logic [7:0]  data_in = '0;
    logic        ready_in, valid_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;

    // RATIO=3 instance
    logic        v3 = 1'b0, l3 = 1'b0, ro3 = 1'b0;
    logic [7:0]  d3 = '0;
    logic        ri3, vo3, lo3;
    logic [23:0] do3;
    logic [2:0]  k3;

    stream_upsizer #(.DATA_WD(8), .RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .last_in(last_in), .ready_in(ready_in), .valid_out(valid_out),
        .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out)
    );

    stream_upsizer #(.DATA_WD(8), .RATIO(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .valid_in(v3), .data_in(d3),
        .last_in(l3), .ready_in(ri3), .valid_out(vo3),
        .data_out(do3), .keep_out(k3), .last_out(lo3),
        .ready_out(ro3)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: {data, keep, last}
    logic [36:0] exp_q[$];
    logic [27:0] exp3_q[$];

    logic [31:0] m_word = '0;
    logic [3:0]  m_keep = '0;
    int          m_cnt  = 0;
    logic [23:0] m3_word = '0;
    logic [2:0]  m3_keep = '0;
    int          m3_cnt  = 0;

    task automatic model_beat(input logic [7:0] d, input logic l);
        m_word[m_cnt*8 +: 8] = d;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == 3 || l) begin
            exp_q.push_back({m_word, m_keep, l});
            m_word = '0; m_keep = '0; m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model3_beat(input logic [7:0] d, input logic l);
        m3_word[m3_cnt*8 +: 8] = d;
        m3_keep[m3_cnt] = 1'b1;
        if (m3_cnt == 2 || l) begin
            exp3_q.push_back({m3_word, m3_keep, l});
            m3_word = '0; m3_keep = '0; m3_cnt = 0;
        end else begin
            m3_cnt++;
        end
    endtask

    logic low_seen = 1'b0;

    task automatic send_beat(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        valid_in = 1'b1; data_in = d; last_in = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!ready_in) low_seen = 1'b1;
            if (ready_in) begin ok = 1'b1; break; end
        end
        if (!ok) check("beat_accept_timeout", ok, 1);
        @(posedge clk);
        if (ok) model_beat(d, l);
        #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic send_beat3(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        v3 = 1'b1; d3 = d; l3 = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ri3) begin ok = 1'b1; break; end
        end
        if (!ok) check("beat3_accept_timeout", ok, 1);
        @(posedge clk);
        if (ok) model3_beat(d, l);
        #1;
        v3 = 1'b0; l3 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            if (exp_q.size() == 0) check("out_unexpected", exp_q.size(), 1);
            else check("out_word", {data_out, keep_out, last_out}, exp_q.pop_front());
        end
        if (rst_n && vo3 && ro3) begin
            if (exp3_q.size() == 0) check("out3_unexpected", exp3_q.size(), 1);
            else check("out3_word", {do3, k3, lo3}, exp3_q.pop_front());
        end
    end

    logic [36:0] held;

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_keep_out", keep_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ready_in", ready_in, 1);
        rst_n = 1'b1;
        ready_out = 1'b1;
        ro3 = 1'b1;

        // 1: full word, one cycle latency
        send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0);
        send_beat(8'h44, 0);
        check("t1_valid", valid_out, 1);
        check("t1_data", data_out, 32'h44332211);
        check("t1_keep", keep_out, 4'hF);
        check("t1_last", last_out, 0);
        @(posedge clk); #1;
        check("t1_drained", valid_out, 0);

        // 2: partial packet
        send_beat(8'hA1, 0); send_beat(8'hA2, 1);
        check("t2_data", data_out, 32'h0000A2A1);
        check("t2_keep", keep_out, 4'b0011);
        check("t2_last", last_out, 1);
        @(posedge clk); #1;

        // 3: backpressure, then drain with a beat landing in lane 0
        ready_out = 1'b0;
        send_beat(8'hB1, 0); send_beat(8'hB2, 0); send_beat(8'hB3, 0); send_beat(8'hB4, 0);
        held = {32'hB4B3B2B1, 4'hF, 1'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_ready_in_low", ready_in, 0);
            check("t3_valid_held", valid_out, 1);
            check("t3_word_held", {data_out, keep_out, last_out}, held);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        send_beat(8'h55, 0);
        check("t3_lane0_data", data_out, 32'h00000055);
        check("t3_lane0_keep", keep_out, 4'h1);
        check("t3_after_drain_valid", valid_out, 0);
        send_beat(8'h66, 0); send_beat(8'h77, 0); send_beat(8'h88, 0);
        @(posedge clk); #1;

        // 4: streaming 16 beats
        low_seen = 1'b0;
        for (int b = 0; b < 16; b++) send_beat(8'(b), 0);
        repeat (2) @(posedge clk); #1;
        check("t4_ready_never_low", low_seen, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset mid-word
        send_beat(8'hC1, 0); send_beat(8'hC2, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        m_word = '0; m_keep = '0; m_cnt = 0;
        check("t5_valid", valid_out, 0);
        check("t5_keep", keep_out, 0);
        check("t5_data", data_out, 0);
        check("t5_ready_in", ready_in, 1);
        rst_n = 1'b1;
        send_beat(8'hD1, 0); send_beat(8'hD2, 0); send_beat(8'hD3, 0); send_beat(8'hD4, 0);
        check("t5_fresh_word", data_out, 32'hD4D3D2D1);
        check("t5_fresh_keep", keep_out, 4'hF);
        @(posedge clk); #1;

        // 6: RATIO=3, last on lane 0 while HOLD drains
        ro3 = 1'b0;
        send_beat3(8'hE1, 0); send_beat3(8'hE2, 0); send_beat3(8'hE3, 0);
        check("t6_hold", vo3, 1);
        check("t6_hold_data", do3, 24'hE3E2E1);
        ro3 = 1'b1;
        send_beat3(8'hF0, 1);
        check("t6_rehold_valid", vo3, 1);
        check("t6_rehold_keep", k3, 3'b001);
        check("t6_rehold_last", lo3, 1);
        check("t6_rehold_data", do3, 24'h0000F0);
        @(posedge clk); #1;
        for (int b = 1; b <= 5; b++) send_beat3(8'(b), (b == 5));
        check("t6_tail_keep", k3, 3'b011);
        repeat (3) @(posedge clk); #1;
        check("t6_queue_empty", exp3_q.size(), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
